// File: rtl/mem_wb_stage.sv
// mem_wb_stage
// MEM/WB pipeline register and write-back stage for the 16-bit processor.
// It holds the selected write-back value and destination for one cycle and
// presents them as the register-file write port. That port is also the
// forwarding source for earlier stages. It also counts retired instructions.
module mem_wb_stage #(
   parameter int DATA_WIDTH     = 16,
   parameter int REG_ADDR_WIDTH = 4
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      stall,
   input  logic                      flush,
   input  logic                      inValid,
   input  logic                      RegWrite,
   input  logic                      MemtoReg,
   input  logic                      RegDst,
   input  logic [REG_ADDR_WIDTH-1:0] rt,
   input  logic [REG_ADDR_WIDTH-1:0] rd,
   input  logic [DATA_WIDTH-1:0]     aluResult,
   input  logic [DATA_WIDTH-1:0]     memData,
   output logic                      outValid,
   output logic                      wbEnable,
   output logic [REG_ADDR_WIDTH-1:0] wbAddr,
   output logic [DATA_WIDTH-1:0]     wbData,
   output logic [15:0]               retired
);

   logic                      validQ;
   logic                      regWriteQ;
   logic [REG_ADDR_WIDTH-1:0] addrQ;
   logic [DATA_WIDTH-1:0]     dataQ;

   // Stage register. Reset clears everything. A flush loads a bubble but
   // keeps the retired count. A stall freezes all state. Otherwise the
   // stage captures the write-back selection made from the MEM-stage inputs.
   // The retired count advances only for real instructions and wraps silently.
   always_ff @(posedge clock) begin
      if (reset) begin
         validQ    <= 1'b0;
         regWriteQ <= 1'b0;
         addrQ     <= '0;
         dataQ     <= '0;
         retired   <= '0;
      end else if (flush) begin
         validQ    <= 1'b0;
         regWriteQ <= 1'b0;
         addrQ     <= '0;
         dataQ     <= '0;
      end else if (!stall) begin
         validQ    <= inValid;
         regWriteQ <= RegWrite & inValid;
         addrQ     <= RegDst ? rd : rt;
         dataQ     <= MemtoReg ? memData : aluResult;
         if (inValid) begin
            retired <= retired + 16'd1;
         end
      end
   end

   // The write port comes straight from the registers. Register 0 is hardwired,
   // so a destination of 0 never asserts the enable. This also keeps such
   // a destination from producing a forwarding hit.
   assign outValid = validQ;
   assign wbAddr   = addrQ;
   assign wbData   = dataQ;
   assign wbEnable = regWriteQ & validQ & (addrQ != '0);

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage
// Drives directed and random traffic into mem_wb_stage. Every output is
// compared after each rising edge against a reference model of the stage
// that the bench computes from the stage's rules.
module tb_mem_wb_stage;

   logic        clock = 1'b0;
   logic        reset, stall, flush, inValid, RegWrite, MemtoReg, RegDst;
   logic [3:0]  rt, rd;
   logic [15:0] aluResult, memData;
   logic        outValid, wbEnable;
   logic [3:0]  wbAddr;
   logic [15:0] wbData, retired;

   int errorCount = 0;
   int checkCount = 0;

   // Reference state: what the stage should be holding right now
   bit  refValid;
   bit  refWrite;
   int  refAddr;
   int  refData;
   int  refRetired;

   mem_wb_stage #(.DATA_WIDTH(16), .REG_ADDR_WIDTH(4)) dut (
      .clock(clock), .reset(reset), .stall(stall), .flush(flush),
      .inValid(inValid), .RegWrite(RegWrite), .MemtoReg(MemtoReg),
      .RegDst(RegDst), .rt(rt), .rd(rd), .aluResult(aluResult),
      .memData(memData), .outValid(outValid), .wbEnable(wbEnable),
      .wbAddr(wbAddr), .wbData(wbData), .retired(retired)
   );

   // Free-running clock with a 10-unit period
   always #5 clock = ~clock;

   // Single comparison point for every check in the bench
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                  tag, observed, expected, $time);
      end
   endtask

   // Compare all outputs with the reference model
   task automatic checkAll();
      bit expEnable;
      expEnable = refValid && refWrite && (refAddr != 0);
      checkOutput("outValid", {31'd0, outValid}, {31'd0, refValid});
      checkOutput("wbEnable", {31'd0, wbEnable}, {31'd0, expEnable});
      checkOutput("wbAddr",   {28'd0, wbAddr},   refAddr);
      checkOutput("wbData",   {16'd0, wbData},   refData);
      checkOutput("retired",  {16'd0, retired},  refRetired);
   endtask

   // Drive one cycle of inputs and advance the model at the edge.
   // Then compare all outputs a little after that edge.
   task automatic applyStimulus(input bit rst, input bit fl, input bit st,
                                input bit iv, input bit rw, input bit m2r,
                                input bit rdst, input int rtV, input int rdV,
                                input int alu, input int mem);
      reset = rst; flush = fl; stall = st; inValid = iv; RegWrite = rw;
      MemtoReg = m2r; RegDst = rdst; rt = rtV[3:0]; rd = rdV[3:0];
      aluResult = alu[15:0]; memData = mem[15:0];
      @(posedge clock);
      if (rst) begin
         refValid = 0; refWrite = 0; refAddr = 0; refData = 0; refRetired = 0;
      end else if (fl) begin
         refValid = 0; refWrite = 0; refAddr = 0; refData = 0;
      end else if (!st) begin
         refValid = iv;
         refWrite = rw && iv;
         refAddr  = (rdst ? rdV : rtV) % 16;
         refData  = (m2r ? mem : alu) % 65536;
         if (iv) refRetired = (refRetired + 1) % 65536;
      end
      #1;
      checkAll();
   endtask

   initial begin
      refValid = 0; refWrite = 0; refAddr = 0; refData = 0; refRetired = 0;
      reset = 1; stall = 0; flush = 0; inValid = 0; RegWrite = 0;
      MemtoReg = 0; RegDst = 0; rt = 0; rd = 0; aluResult = 0; memData = 0;

      // Reset for two cycles, then idle
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("resetRetired", {16'd0, retired}, 0);
      applyStimulus(0, 0, 0, 0, 1, 0, 1, 7, 9, 16'h5555, 16'hAAAA);
      applyStimulus(0, 0, 0, 0, 1, 1, 0, 7, 9, 16'h5555, 16'hAAAA);
      checkOutput("idleEnable", {31'd0, wbEnable}, 0);

      // ALU op written to rd
      applyStimulus(0, 0, 0, 1, 1, 0, 1, 2, 5, 16'h1234, 16'h9999);
      checkOutput("aluAddr", {28'd0, wbAddr}, 5);
      checkOutput("aluData", {16'd0, wbData}, 16'h1234);
      checkOutput("aluRetired", {16'd0, retired}, 1);

      // Load written to rt, then a load targeting register 0
      applyStimulus(0, 0, 0, 1, 1, 1, 0, 3, 6, 16'h0010, 16'hBEEF);
      checkOutput("loadData", {16'd0, wbData}, 16'hBEEF);
      applyStimulus(0, 0, 0, 1, 1, 1, 0, 0, 6, 16'h0010, 16'hBEEF);
      checkOutput("loadR0Enable", {31'd0, wbEnable}, 0);
      checkOutput("loadR0Retired", {16'd0, retired}, 3);

      // Capture a write, stall three cycles with new inputs, then stall+flush
      applyStimulus(0, 0, 0, 1, 1, 0, 1, 1, 12, 16'h4321, 16'h0);
      for (int i = 0; i < 3; i++)
         applyStimulus(0, 0, 1, 1, 1, 1, 0, 8 + i, 3, 16'h1111 * i, 16'h7777);
      checkOutput("stallData", {16'd0, wbData}, 16'h4321);
      checkOutput("stallEnable", {31'd0, wbEnable}, 1);
      applyStimulus(0, 1, 1, 1, 1, 0, 1, 4, 4, 16'hFFFF, 16'hFFFF);
      checkOutput("flushValid", {31'd0, outValid}, 0);
      checkOutput("flushRetired", {16'd0, retired}, 4);

      // Random traffic with occasional stall, flush and reset
      for (int i = 0; i < 400; i++) begin
         applyStimulus($urandom_range(0, 49) == 0, $urandom_range(0, 9) == 0,
                       $urandom_range(0, 4) == 0, $urandom_range(0, 3) != 0,
                       $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                       $urandom_range(0, 1) == 1, $urandom_range(0, 15),
                       $urandom_range(0, 15), $urandom_range(0, 65535),
                       $urandom_range(0, 65535));
      end

      // Mid-stream reset: back-to-back writes, a reset edge, then a resumed capture
      applyStimulus(0, 0, 0, 1, 1, 0, 1, 0, 7, 16'h0A0A, 0);
      applyStimulus(0, 0, 0, 1, 1, 0, 1, 0, 8, 16'h0B0B, 0);
      applyStimulus(1, 0, 0, 1, 1, 0, 1, 0, 9, 16'h0C0C, 0);
      checkOutput("midResetData", {16'd0, wbData}, 0);
      applyStimulus(0, 0, 0, 1, 1, 0, 1, 0, 10, 16'h0D0D, 0);
      checkOutput("resumeAddr", {28'd0, wbAddr}, 10);
      checkOutput("resumeRetired", {16'd0, retired}, 1);

      // Counter wrap starting from a clean reset
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 65535; i++)
         applyStimulus(0, 0, 0, 1, i[0], i[1], i[2], i % 16, (i / 16) % 16,
                       i % 65536, (i * 7) % 65536);
      checkOutput("wrapMax", {16'd0, retired}, 16'hFFFF);
      applyStimulus(0, 0, 0, 1, 1, 0, 1, 0, 3, 16'h2222, 0);
      checkOutput("wrapZero", {16'd0, retired}, 0);

      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Pipeline register and write-back stage directly downstream of the MEM stage of the 16-bit processor. It captures the MEM stage's load data (`outputDataRead`) together with the ALU result and the write-back control bits. It selects the write-back value and destination register and presents a registered register-file write port, which also serves as the forwarding source. It supports stall, flush and bubble tracking, and keeps a retired-instruction counter.

## Interface
- `DATA_WIDTH`, 16, width of data path
- `REG_ADDR_WIDTH`, 4, register-file address width
- `clock`  in  1  system clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high reset
- `stall`  in  1  hold all stage state this cycle
- `flush`  in  1  load a bubble this cycle
- `inValid`  in  1  instruction presented by MEM stage is real (not a bubble)
- `RegWrite`  in  1  instruction writes the register file
- `MemtoReg`  in  1  1: write back `memData`; 0: write back `aluResult`
- `RegDst`  in  1  1: destination is `rd`; 0: destination is `rt`
- `rt`  in  REG_ADDR_WIDTH  rt field
- `rd`  in  REG_ADDR_WIDTH  rd field
- `aluResult`  in  DATA_WIDTH  address/ALU result from EX/MEM
- `memData`  in  DATA_WIDTH  data read by MEM stage data memory
- `outValid`  out  1  registered instruction is real
- `wbEnable`  out  1  register-file write enable
- `wbAddr`  out  REG_ADDR_WIDTH  register-file write address
- `wbData`  out  DATA_WIDTH  register-file write data
- `retired`  out  16  count of valid instructions captured, wraps

## Operation
- Internal registers: `validQ`, `regWriteQ`, `addrQ`, `dataQ`, `retired`.
- Update priority per rising edge: reset > flush > stall > capture.
- Reset: all registers are set to 0, including `retired`.
- Flush: `validQ`=0, `regWriteQ`=0, `addrQ`=0, `dataQ`=0. `retired` holds.
- Stall without flush: all registers hold, including `retired`.
- Capture (no reset/flush/stall):
  - `validQ` ← `inValid`
  - `regWriteQ` ← `RegWrite & inValid`
  - `addrQ` ← `RegDst ? rd : rt`
  - `dataQ` ← `MemtoReg ? memData : aluResult`
  - `retired` ← `retired + 1` when `inValid`=1, else hold.
- `retired` is modulo 2^16: 0xFFFF + 1 → 0x0000 with no flag.
- Outputs:
  - `outValid` = `validQ`
  - `wbAddr` = `addrQ`
  - `wbData` = `dataQ`
  - `wbEnable` = `regWriteQ & validQ & (addrQ != 0)`. Register 0 is never written, and a destination of 0 gives no forwarding hit.
- `wbData`/`wbAddr` may hold stale values while `wbEnable`=0. Consumers qualify them with `wbEnable` only.
- Control inputs with `inValid`=0 have no effect on writes.

## Timing
- Latency: 1 cycle. Inputs sampled at edge N appear on outputs after edge N and hold until the next capture/flush/reset edge.
- All outputs come directly from registers (plus the `wbEnable` AND/compare). There is no combinational path from any input to any output.
- Reset values: `outValid`=0, `wbEnable`=0, `wbAddr`=0, `wbData`=0, `retired`=0.
- Reset asserted mid-stream discards the held instruction. The first capture happens on the first edge with `reset`=0.
- `flush` and `stall` together: flush wins, a bubble is loaded, and `retired` is unchanged.
- Stall for k cycles: outputs are constant for k cycles. `wbEnable` stays asserted if it was asserted, so the register file rewrites the same value (idempotent).
- `memData` and `aluResult` are sampled on the same edge. The MEM stage guarantees `memData` is valid at that edge for loads.

## Test plan
- Reset then idle: `reset`=1 for 2 cycles → all outputs 0; release with `inValid`=0 → outputs stay 0 and `retired`=0.
- ALU op: `inValid`=1, `RegWrite`=1, `MemtoReg`=0, `RegDst`=1, `rd`=5, `aluResult`=0x1234 → next cycle `wbEnable`=1, `wbAddr`=5, `wbData`=0x1234, `retired`=1.
- Load: `MemtoReg`=1, `RegDst`=0, `rt`=3, `memData`=0xBEEF, `aluResult`=0x0010 → `wbAddr`=3, `wbData`=0xBEEF. Same with `rt`=0 → `wbEnable`=0, `retired` still increments.
- Stall/flush: capture a valid write, then `stall`=1 for 3 cycles with new inputs → outputs and `retired` are frozen. Then `stall`=1 with `flush`=1 → `outValid`=0, `wbEnable`=0, `retired` unchanged.
- Counter wrap: 65535 valid captures → `retired`=0xFFFF; one more → 0x0000.
- Mid-stream reset: valid writes on consecutive cycles, then `reset`=1 for one edge → all outputs 0 the next cycle, and capture resumes on the following edge.
